z80_int_daisy: RTL and testbench

- Interrupt daisy-chain controller for Z80-style peripherals such as the PIO port-B interrupt source. It shares the CPU's single INT_n line between N requesters with fixed priority.
- It answers the CPU interrupt-acknowledge cycle with the winning device's 8-bit vector and tracks which devices are in service.
- It snoops opcode fetches for RETI (ED 4D) to retire in-service devices.
- It sits between the CPU bus and the peripheral cluster. IEI/IEO allow it to be chained with other daisy-chain devices.

---
 rtl/z80_bus_pkg.sv | 16 +
 rtl/z80_reti_decoder.sv | 64 ++++++
 rtl/z80_int_daisy.sv | 123 ++++++++++++
 tb/tb_z80_int_daisy.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/z80_bus_pkg.sv
// Shared Z80 bus constants and the RETI snoop state encoding.
`default_nettype none

package z80_bus_pkg;

  localparam logic [7:0] OPC_RETI_PREFIX = 8'hED;
  localparam logic [7:0] OPC_RETI        = 8'h4D;

  typedef enum logic {
    IDLE   = 1'b0,
    GOT_ED = 1'b1
  } reti_state_t;

endpackage

`default_nettype wire

// File: rtl/z80_reti_decoder.sv
// Snoops CPU opcode fetches and pulses reti_evt when the ED 4D (RETI) sequence completes.
`default_nettype none

module z80_reti_decoder
  import z80_bus_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       ENA,
  input  logic       M1_n,
  input  logic       RD_n,
  input  logic       IORQ_n,
  input  logic [7:0] DI,
  output logic       reti_evt
);

  reti_state_t state, state_nxt;
  logic        sampled;
  logic        fetch;
  logic        sample;

  assign fetch  = ~M1_n & ~RD_n & IORQ_n;
  // A fetch may span several ENA cycles; only its first one looks at DI.
  assign sample = ENA & fetch & ~sampled;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      sampled <= 1'b0;
    end else if (ENA) begin
      state <= state_nxt;
      if (M1_n)
        sampled <= 1'b0;
      else if (fetch)
        sampled <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    reti_evt  = 1'b0;
    if (sample) begin
      case (state)
        IDLE: begin
          state_nxt = (DI == OPC_RETI_PREFIX) ? GOT_ED : IDLE;
        end
        GOT_ED: begin
          if (DI == OPC_RETI) begin
            reti_evt  = 1'b1;
            state_nxt = IDLE;
          end else if (DI == OPC_RETI_PREFIX) begin
            state_nxt = GOT_ED;
          end else begin
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/z80_int_daisy.sv
// Fixed-priority Z80 interrupt daisy chain: request capture, INTA vectoring, in-service tracking.
`default_nettype none

module z80_int_daisy
  import z80_bus_pkg::*;
#(
  parameter int N = 4
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           ENA,
  input  logic           M1_n,
  input  logic           IORQ_n,
  input  logic           RD_n,
  input  logic [7:0]     DI,
  input  logic           IEI,
  output logic           IEO,
  output logic           INT_n,
  output logic [7:0]     DO,
  output logic           VECTEN,
  input  logic [N-1:0]   REQ,
  input  logic [8*N-1:0] VECT,
  output logic [N-1:0]   ACK,
  output logic [N-1:0]   INSRV,
  output logic [N-1:0]   PEND
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]     pend, isr, req_d, ack;
  logic [N-1:0]     pend_nxt, isr_nxt, elig, isr_lowest;
  logic [IDX_W-1:0] ack_idx, win_idx;
  logic             win_vld, inta, inta_d, inta_start, ack_go, vecten, reti_evt;
  logic             blocked;

  z80_reti_decoder u_reti (
    .CLK      (CLK),
    .RST      (RST),
    .ENA      (ENA),
    .M1_n     (M1_n),
    .RD_n     (RD_n),
    .IORQ_n   (IORQ_n),
    .DI       (DI),
    .reti_evt (reti_evt)
  );

  assign inta       = ~M1_n & ~IORQ_n;
  assign inta_start = inta & ~inta_d;
  assign ack_go     = inta_start & win_vld;

  // A device is masked by its own or any higher-priority in-service bit.
  always_comb begin
    blocked = 1'b0;
    elig    = '0;
    for (int i = 0; i < N; i++) begin
      blocked = blocked | isr[i];
      elig[i] = pend[i] & IEI & ~blocked;
    end
  end

  always_comb begin
    win_vld    = 1'b0;
    win_idx    = '0;
    isr_lowest = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (elig[i]) begin
        win_vld = 1'b1;
        win_idx = IDX_W'(i);
      end
      if (isr[i]) begin
        isr_lowest    = '0;
        isr_lowest[i] = 1'b1;
      end
    end
  end

  // RETI retires first, then the acknowledge applies; a fresh REQ edge beats the ack clear.
  always_comb begin
    isr_nxt  = reti_evt ? (isr & ~isr_lowest) : isr;
    pend_nxt = pend;
    if (ack_go) begin
      isr_nxt[win_idx]  = 1'b1;
      pend_nxt[win_idx] = 1'b0;
    end
    pend_nxt = pend_nxt | (REQ & ~req_d);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pend    <= '0;
      isr     <= '0;
      req_d   <= '0;
      ack     <= '0;
      ack_idx <= '0;
      vecten  <= 1'b0;
      inta_d  <= 1'b0;
    end else if (ENA) begin
      pend   <= pend_nxt;
      isr    <= isr_nxt;
      req_d  <= REQ;
      inta_d <= inta;
      ack    <= '0;
      if (ack_go) begin
        ack_idx      <= win_idx;
        ack[win_idx] <= 1'b1;
        vecten       <= 1'b1;
      end else if (!inta) begin
        vecten <= 1'b0;
      end
    end
  end

  assign INT_n  = ~|elig;
  assign IEO    = IEI & ~|isr & ~|pend;
  assign VECTEN = vecten;
  assign DO     = vecten ? VECT[{ack_idx, 3'b000} +: 8] : 8'h00;
  assign ACK    = ack;
  assign INSRV  = isr;
  assign PEND   = pend;

endmodule

`default_nettype wire

// File: tb/tb_z80_int_daisy.sv
// Directed bench for z80_int_daisy: vectoring, priority, nesting, RETI snoop, chain and reset.
`default_nettype none

module tb_z80_int_daisy;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        ENA = 1'b1;
  logic        M1_n = 1'b1;
  logic        IORQ_n = 1'b1;
  logic        RD_n = 1'b1;
  logic [7:0]  DI = 8'h00;
  logic        IEI = 1'b1;
  logic        IEO;
  logic        INT_n;
  logic [7:0]  DO;
  logic        VECTEN;
  logic [3:0]  REQ = 4'b0000;
  logic [31:0] VECT = {8'h30, 8'h24, 8'h18, 8'h10};
  logic [3:0]  ACK;
  logic [3:0]  INSRV;
  logic [3:0]  PEND;

  int total = 0;
  int bad   = 0;

  z80_int_daisy #(.N(4)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .ENA    (ENA),
    .M1_n   (M1_n),
    .IORQ_n (IORQ_n),
    .RD_n   (RD_n),
    .DI     (DI),
    .IEI    (IEI),
    .IEO    (IEO),
    .INT_n  (INT_n),
    .DO     (DO),
    .VECTEN (VECTEN),
    .REQ    (REQ),
    .VECT   (VECT),
    .ACK    (ACK),
    .INSRV  (INSRV),
    .PEND   (PEND)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fetch(input logic [7:0] op);
    M1_n = 1'b0; RD_n = 1'b0; IORQ_n = 1'b1; DI = op;
    tick();
    tick();
    M1_n = 1'b1; RD_n = 1'b1;
    tick();
  endtask

  task automatic inta_begin();
    M1_n = 1'b0; IORQ_n = 1'b0;
    tick();
  endtask

  task automatic inta_end();
    tick();
    check("ack_one_cycle", {28'd0, ACK}, 32'h0);
    M1_n = 1'b1; IORQ_n = 1'b1;
    tick();
    check("vecten_drop", {31'd0, VECTEN}, 32'h0);
    check("do_idle", {24'd0, DO}, 32'h0);
  endtask

  initial begin
    tick();
    tick();
    check("rst_int_n", {31'd0, INT_n}, 32'h1);
    check("rst_do", {24'd0, DO}, 32'h0);
    check("rst_ieo", {31'd0, IEO}, 32'h1);
    check("rst_insrv", {28'd0, INSRV}, 32'h0);
    check("rst_pend", {28'd0, PEND}, 32'h0);
    RST = 1'b0;
    tick();

    // single request on device 2
    REQ = 4'b0100;
    tick();
    check("s_pend", {28'd0, PEND}, 32'h4);
    check("s_int_n", {31'd0, INT_n}, 32'h0);
    check("s_ieo", {31'd0, IEO}, 32'h0);
    inta_begin();
    check("s_do", {24'd0, DO}, 32'h24);
    check("s_vecten", {31'd0, VECTEN}, 32'h1);
    check("s_ack", {28'd0, ACK}, 32'h4);
    check("s_insrv", {28'd0, INSRV}, 32'h4);
    check("s_pend_clr", {28'd0, PEND}, 32'h0);
    check("s_int_n_hi", {31'd0, INT_n}, 32'h1);
    inta_end();

    // nesting: device 0 interrupts device 2
    REQ = 4'b0101;
    tick();
    check("n_int_n", {31'd0, INT_n}, 32'h0);
    inta_begin();
    check("n_do", {24'd0, DO}, 32'h10);
    check("n_ack", {28'd0, ACK}, 32'h1);
    check("n_insrv", {28'd0, INSRV}, 32'h5);
    inta_end();
    fetch(8'hED); fetch(8'hED); fetch(8'h4D);
    check("n_reti1", {28'd0, INSRV}, 32'h4);
    fetch(8'hED); fetch(8'h4D);
    check("n_reti2", {28'd0, INSRV}, 32'h0);
    REQ = 4'b0000;
    tick();

    // priority: devices 1 and 3 together
    REQ = 4'b1010;
    tick();
    check("p_pend", {28'd0, PEND}, 32'hA);
    inta_begin();
    check("p_do", {24'd0, DO}, 32'h18);
    check("p_ack", {28'd0, ACK}, 32'h2);
    check("p_pend3", {28'd0, PEND}, 32'h8);
    check("p_int_n_blk", {31'd0, INT_n}, 32'h1);
    inta_end();
    fetch(8'hED); fetch(8'h00); fetch(8'h4D);
    check("p_no_reti", {28'd0, INSRV}, 32'h2);
    fetch(8'hED); fetch(8'h4D);
    check("p_reti", {28'd0, INSRV}, 32'h0);
    check("p_int_n_lo", {31'd0, INT_n}, 32'h0);
    inta_begin();
    check("p_do3", {24'd0, DO}, 32'h30);
    check("p_insrv3", {28'd0, INSRV}, 32'h8);
    inta_end();

    // plain memory read of ED 4D must not retire
    RD_n = 1'b0; DI = 8'hED; tick();
    DI = 8'h4D; tick();
    RD_n = 1'b1; tick();
    check("m_ignored", {28'd0, INSRV}, 32'h8);
    fetch(8'hED); fetch(8'h4D);
    check("m_reti", {28'd0, INSRV}, 32'h0);
    fetch(8'hED); fetch(8'h4D);
    check("z_reti_isr", {28'd0, INSRV}, 32'h0);
    check("z_reti_pend", {28'd0, PEND}, 32'h0);
    REQ = 4'b0000;
    tick();

    // new edge coinciding with the acknowledge keeps the device pending
    REQ = 4'b0100; tick();
    REQ = 4'b0000; tick();
    REQ = 4'b0100;
    inta_begin();
    check("c_ack", {28'd0, ACK}, 32'h4);
    check("c_pend_kept", {28'd0, PEND}, 32'h4);
    check("c_int_n_blk", {31'd0, INT_n}, 32'h1);
    inta_end();
    fetch(8'hED); fetch(8'h4D);
    check("c_int_n_again", {31'd0, INT_n}, 32'h0);
    inta_begin();
    check("c_pend_clr", {28'd0, PEND}, 32'h0);
    inta_end();
    fetch(8'hED); fetch(8'h4D);
    REQ = 4'b0000;
    tick();

    // chain blocked and empty acknowledge
    IEI = 1'b0;
    REQ = 4'b0001;
    tick();
    check("e_pend", {28'd0, PEND}, 32'h1);
    check("e_int_n", {31'd0, INT_n}, 32'h1);
    check("e_ieo", {31'd0, IEO}, 32'h0);
    inta_begin();
    check("e_vecten", {31'd0, VECTEN}, 32'h0);
    check("e_do", {24'd0, DO}, 32'h0);
    check("e_ack", {28'd0, ACK}, 32'h0);
    check("e_insrv", {28'd0, INSRV}, 32'h0);
    inta_end();
    check("e_pend_hold", {28'd0, PEND}, 32'h1);

    // reset in the middle of an acknowledge
    IEI = 1'b1;
    tick();
    check("r_int_n", {31'd0, INT_n}, 32'h0);
    inta_begin();
    check("r_vecten", {31'd0, VECTEN}, 32'h1);
    check("r_do", {24'd0, DO}, 32'h10);
    #2;
    RST = 1'b1;
    #1;
    check("r_async_vecten", {31'd0, VECTEN}, 32'h0);
    check("r_async_do", {24'd0, DO}, 32'h0);
    check("r_async_int_n", {31'd0, INT_n}, 32'h1);
    check("r_async_insrv", {28'd0, INSRV}, 32'h0);
    check("r_async_pend", {28'd0, PEND}, 32'h0);
    M1_n = 1'b1; IORQ_n = 1'b1;
    tick();
    RST = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
